sec_countdown_timer: RTL
========================

// Module: sec_countdown_timer
// PURPOSE
//  Parametrised second-tick generator with a loadable seconds countdown timer for the traffic controller.
//  Prescaler divides clk down to a one-cycle sec_tick every TICKS_PER_SEC cycles.
//  The countdown holds phase durations (green/amber/red) in seconds and pulses done at expiry.
//  The FSM drives load/pause and consumes done; other blocks may use sec_tick directly.
// PARAMETERS
//  TICKS_PER_SEC  50000000  clk cycles per second tick; >=1
//  PRESCALE_W     26        prescaler counter width; must hold TICKS_PER_SEC-1 (elaboration error otherwise)
//  SEC_W          8         width of load_value / remaining (max 2^SEC_W-1 s)
// PORTS
//  clk              in   1      system clock, rising edge
//  divider_reset_n  in   1      asynchronous active-low reset
//  sync_clr         in   1      synchronous clear of prescaler and timer
//  enable           in   1      1 = prescaler counts; 0 = prescaler and timer frozen
//  load             in   1      1-cycle strobe: start/restart countdown with load_value
//  load_value       in   SEC_W  countdown length in seconds, sampled when load=1
//  pause            in   1      level; 1 = freeze prescaler and countdown
//  sec_tick         out  1      1-cycle pulse once per second (registered)
//  busy             out  1      1 while countdown is RUN or PAUSE
//  remaining        out  SEC_W  seconds left (registered)
//  done             out  1      1-cycle pulse when countdown reaches 0
// BEHAVIOUR
//  Reset (async, divider_reset_n=0): prescale=0, state=IDLE, sec_tick=0, done=0, busy=0, remaining=0.
//  Priority per edge: reset > sync_clr > load > pause/enable > terminal tick.
//  Prescaler: run = enable & ~pause. If run and prescale==TICKS_PER_SEC-1:
//   prescale<=0, sec_tick<=1 ("terminal"). Else if run: prescale+1, sec_tick<=0. Else hold, sec_tick<=0.
//   TICKS_PER_SEC=1: sec_tick high every running cycle.
//  sync_clr: prescale<=0, sec_tick<=0, done<=0, remaining<=0, state<=IDLE.
//  FSM states IDLE, RUN, PAUSE; busy=1 in RUN/PAUSE.
//   load (any state): remaining<=load_value, prescale<=0 (full first second), sec_tick<=0.
//    load_value!=0 -> RUN. load_value==0 -> done<=1 next cycle, stay/return IDLE.
//    load overrides a coincident terminal: no decrement, no done.
//   RUN & pause -> PAUSE; PAUSE & ~pause -> RUN. No tick, no decrement in PAUSE.
//   RUN & terminal: remaining<=remaining-1; if remaining==1 -> remaining<=0, done<=1, state<=IDLE.
//   IDLE: terminals still produce sec_tick; remaining holds; no done.
//  Latency: load at edge k, enable=1, no pause, load_value=N>0 ->
//   decrements at edges k+TICKS_PER_SEC*i; done high in the cycle after edge k+N*TICKS_PER_SEC.
//  enable=0 in RUN: state stays RUN, prescale and remaining frozen.
//  done and sec_tick never stretch beyond 1 cycle; remaining never wraps below 0.
// TESTING (TICKS_PER_SEC=4, SEC_W=4, PRESCALE_W=2)
//  1. Release reset, enable=1 -> sec_tick high 1 cycle after edges 4,8,12; low otherwise.
//  2. load=1, load_value=3 -> busy=1; remaining 3->2->1->0 at +4,+8,+12; done 1 pulse at +12, busy=0.
//  3. load_value=0 with load -> done high exactly 1 cycle later; busy stays 0; remaining=0.
//  4. load 2, pause=1 for 5 cycles at +2 -> no sec_tick during pause; done at +13 instead of +8.
//  5. RUN remaining=2, load 5 on terminal edge -> remaining=5, no done, next decrement 4 cycles later.
//  6. divider_reset_n low mid-RUN (asynchronously) -> all outputs 0 before next edge; sync_clr does same on edge.

Source files
------------

// File: rtl/sec_countdown_timer.sv
// Prescaled one-second tick generator with a loadable seconds countdown.
// The countdown runs in RUN, freezes in PAUSE, and pulses done once on expiry.
module sec_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned PRESCALE_W    = 26,
  parameter int unsigned SEC_W         = 8
) (
  input  logic             clk,
  input  logic             divider_reset_n,
  input  logic             sync_clr,
  input  logic             enable,
  input  logic             load,
  input  logic [SEC_W-1:0] load_value,
  input  logic             pause,
  output logic             sec_tick,
  output logic             busy,
  output logic [SEC_W-1:0] remaining,
  output logic             done
);

  if (TICKS_PER_SEC < 1 ||
      ((64'(TICKS_PER_SEC) - 64'd1) >> PRESCALE_W) != 64'd0) begin : g_bad_param
    $error("sec_countdown_timer: PRESCALE_W too small for TICKS_PER_SEC-1");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] prescale;
  logic [1:0]            state;
  logic                  run;
  logic                  terminal;

  always_comb begin
    run      = enable & ~pause;
    terminal = run && (prescale == LAST);
    busy     = (state == ST_RUN) || (state == ST_PAUSE);
  end

  always_ff @(posedge clk or negedge divider_reset_n) begin
    if (!divider_reset_n) begin
      prescale  <= '0;
      state     <= ST_IDLE;
      sec_tick  <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else if (sync_clr) begin
      prescale  <= '0;
      state     <= ST_IDLE;
      sec_tick  <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else if (load) begin
      // Restart gives a full first second; a zero length expires immediately.
      prescale  <= '0;
      sec_tick  <= 1'b0;
      remaining <= load_value;
      if (load_value == '0) begin
        done  <= 1'b1;
        state <= ST_IDLE;
      end else begin
        done  <= 1'b0;
        state <= ST_RUN;
      end
    end else begin
      done     <= 1'b0;
      sec_tick <= terminal;
      if (run) begin
        prescale <= terminal ? '0 : prescale + PRESCALE_W'(1);
      end
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_RUN, ST_PAUSE: begin
          // A terminal can only occur with pause low, so a tick landing on the
          // resume edge still consumes its second.
          if (terminal) begin
            if (remaining == SEC_W'(1)) begin
              remaining <= '0;
              done      <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              remaining <= remaining - SEC_W'(1);
              state     <= ST_RUN;
            end
          end else begin
            state <= pause ? ST_PAUSE : ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
